// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
//   Shares the core's single AXI4 memory port between the IFU (read-only)
//   and the LSU (read and write). One whole transaction is granted at a
//   time, from address handshake to final response. Channels are routed
//   combinationally from the registered grant, so a request reaches the
//   slave one cycle after it is raised.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read-address and read-data channels
//   lsu_ar*/lsu_r*        LSU read-address and read-data channels
//   lsu_aw*/lsu_w*/lsu_b* LSU write-address, write-data, write-response
//   m_ar*/m_r*/m_aw*/m_w*/m_b*  slave-side AXI4 channels
//   err_timeout           sticky: a granted transaction stayed open TIMEOUT cycles
//   grant                 current owner: 00 none, 01 IFU, 10 LSU read, 11 LSU write
module axi_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LSU_STREAK_MAX = 4,
  parameter int TIMEOUT        = 1024
) (
  input  logic                clk,
  input  logic                reset,
  // IFU read
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // slave side
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  // status
  output logic                err_timeout,
  output logic [1:0]          grant
);

  localparam int STREAK_W = $clog2(LSU_STREAK_MAX + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX_V = STREAK_W'(LSU_STREAK_MAX);
  localparam logic [TMO_W-1:0]    TMO_MAX_V    = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0]    TMO_LAST_V   = TMO_W'(TIMEOUT - 1);

  // State encoding doubles as the grant code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RD_IFU = 2'b01,
    RD_LSU = 2'b10,
    WR_LSU = 2'b11
  } state_t;

  state_t              state_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic [TMO_W-1:0]    tmo_cnt_reg;
  logic                err_timeout_reg;

  logic rd_done;
  logic wr_done;
  logic txn_done;

  assign rd_done  = m_rvalid & m_rready & m_rlast;
  assign wr_done  = m_bvalid & m_bready;
  assign txn_done = (state_reg == WR_LSU) ? wr_done : rd_done;

  assign grant       = state_reg;
  assign err_timeout = err_timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      streak_reg      <= '0;
      tmo_cnt_reg     <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tmo_cnt_reg <= '0;
          // A starved IFU beats every LSU request once the streak is full.
          // In the LSU branches below a waiting IFU implies the streak is
          // still below its limit, so the increment saturates by construction.
          if (ifu_arvalid && (streak_reg == STREAK_MAX_V)) begin
            state_reg  <= RD_IFU;
            streak_reg <= '0;
          end else if (lsu_awvalid || lsu_wvalid) begin
            state_reg <= WR_LSU;
            if (ifu_arvalid) streak_reg <= streak_reg + 1'b1;
          end else if (lsu_arvalid) begin
            state_reg <= RD_LSU;
            if (ifu_arvalid) streak_reg <= streak_reg + 1'b1;
          end else if (ifu_arvalid) begin
            state_reg  <= RD_IFU;
            streak_reg <= '0;
          end
        end
        default: begin
          // Hang detection only flags; the transaction keeps its grant.
          if (tmo_cnt_reg == TMO_LAST_V) err_timeout_reg <= 1'b1;
          if (txn_done) begin
            state_reg   <= IDLE;
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg != TMO_MAX_V) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Channel routing from the registered grant; everything not owned is 0.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    m_araddr    = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    case (state_reg)
      RD_IFU: begin
        m_araddr    = ifu_araddr;
        m_arlen     = ifu_arlen;
        m_arsize    = ifu_arsize;
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
      end
      RD_LSU: begin
        m_araddr    = lsu_araddr;
        m_arlen     = lsu_arlen;
        m_arsize    = lsu_arsize;
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
      end
      WR_LSU: begin
        m_awaddr    = lsu_awaddr;
        m_awlen     = lsu_awlen;
        m_awsize    = lsu_awsize;
        m_awvalid   = lsu_awvalid;
        lsu_awready = m_awready;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wlast     = lsu_wlast;
        m_wvalid    = lsu_wvalid;
        lsu_wready  = m_wready;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- 2-master to 1-slave AXI4 arbiter sharing the core's single memory port between the IFU (read-only) and the LSU/MEM stage (read and write).
- Sits between the two stage masters and the memory/xbar slave.
- Grants one whole transaction at a time, from address handshake to final response, and forwards the channels combinationally from the registered grant.
- Provides starvation protection for the IFU and a hang-detect counter.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LSU_STREAK_MAX, 4, consecutive LSU grants allowed while IFU waits before IFU is forced
- TIMEOUT, 1024, cycles a granted transaction may stay open before err_timeout sets

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ifu_araddr/ifu_arlen/ifu_arsize/ifu_arvalid  in  32/8/3/1  IFU read-address request
- ifu_arready  out  1  IFU read-address accept
- ifu_rdata/ifu_rresp/ifu_rlast/ifu_rvalid  out  32/2/1/1  IFU read data
- ifu_rready  in  1  IFU read-data accept
- lsu_araddr/lsu_arlen/lsu_arsize/lsu_arvalid  in  32/8/3/1  LSU read-address request
- lsu_arready  out  1  LSU read-address accept
- lsu_rdata/lsu_rresp/lsu_rlast/lsu_rvalid  out  32/2/1/1  LSU read data
- lsu_rready  in  1  LSU read-data accept
- lsu_awaddr/lsu_awlen/lsu_awsize/lsu_awvalid  in  32/8/3/1  LSU write-address request
- lsu_awready  out  1  LSU write-address accept
- lsu_wdata/lsu_wstrb/lsu_wlast/lsu_wvalid  in  32/4/1/1  LSU write data
- lsu_wready  out  1  LSU write-data accept
- lsu_bresp/lsu_bvalid  out  2/1  LSU write response
- lsu_bready  in  1  LSU write-response accept
- m_ar*/m_aw*/m_w* (same fields as above)  out  mirrored  slave-side request channels
- m_arready/m_awready/m_wready  in  1  slave-side accepts
- m_rdata/m_rresp/m_rlast/m_rvalid  in  32/2/1/1  slave read data
- m_rready  out  1  slave read-data accept
- m_bresp/m_bvalid  in  2/1  slave write response
- m_bready  out  1  slave write-response accept
- err_timeout  out  1  sticky hang flag
- grant  out  2  current owner: 00 none, 01 IFU, 10 LSU read, 11 LSU write

Behaviour:
- Reset:
  - State goes to IDLE; grant = 00.
  - All outputs to both masters and to the slave are 0, including all valids, readies, data and err_timeout.
  - The streak counter and the timeout counter clear to 0.
- States:
  - IDLE: no routing. All master-side readies/valids and slave-side valids/readies are 0.
  - Arbitration is sampled in IDLE and grant is registered, so there is 1 cycle of latency from request to slave-side valid.
  - Priority:
    1. LSU write (lsu_awvalid | lsu_wvalid) -> WR_LSU.
    2. LSU read (lsu_arvalid) -> RD_LSU.
    3. IFU read (ifu_arvalid) -> RD_IFU.
  - Exception: if streak == LSU_STREAK_MAX and ifu_arvalid is high, go to RD_IFU regardless of LSU requests.
- RD_IFU:
  - m_ar* = ifu_ar*; ifu_arready = m_arready.
  - ifu_r* = m_r* and m_rready = ifu_rready.
  - All LSU outputs are 0.
  - Leave to IDLE on m_rvalid & m_rready & m_rlast.
- RD_LSU: same routing as RD_IFU, using the LSU read channels.
- WR_LSU:
  - m_aw*/m_w* = lsu_aw*/lsu_w*; lsu_awready/lsu_wready follow the slave.
  - lsu_b* = m_b* and m_bready = lsu_bready.
  - AW and W may complete in either order or the same cycle.
  - Leave to IDLE on m_bvalid & m_bready.
- Streak counter:
  - Increments when an LSU grant is issued while ifu_arvalid = 1.
  - Clears on any IFU grant.
  - Saturates at LSU_STREAK_MAX.
- Timeout counter:
  - Counts every cycle the state is not IDLE; clears on each return to IDLE.
  - Reaching TIMEOUT sets err_timeout, which stays high until reset.
  - The transaction is not aborted.
- Non-granted masters see arready/awready/wready/rvalid/bvalid = 0; their requests are held by AXI rules and served later.
- A request arriving on the completion cycle is not granted that cycle. The next grant is evaluated in the following IDLE cycle, giving a 1-cycle bubble.
- Multi-beat reads (arlen > 0) stay granted until the beat with rlast.
- Reset asserted mid-transaction aborts to IDLE immediately. The slave is also reset by the same reset.

Test Plan:
- IFU only: ifu_arvalid, addr 0x8000_0000, slave returns 0xDEAD_BEEF with rlast after 3 cycles. Required: grant=01 one cycle after request; ifu_rvalid carries 0xDEAD_BEEF; grant=00 the cycle after the handshake.
- Simultaneous IFU read + LSU write (addr 0x8000_0100, wdata 0x1234_5678, wstrb 0011). Required: WR_LSU first; the slave sees the write; after bvalid, IFU is granted; ifu_arready stays 0 throughout the write.
- LSU read with arlen=3. Required: grant held across 4 beats; release only on the beat with rlast; IFU request during the burst is served afterwards.
- Starvation guard: IFU held valid while LSU issues back-to-back reads. Required: after 4 LSU grants, the 5th grant goes to IFU even though LSU is requesting.
- Timeout: slave never asserts bvalid. Required: err_timeout rises after exactly 1024 non-IDLE cycles and stays high; reset clears it and returns grant to 00.
- Reset mid-read: reset asserted while RD_LSU is waiting for rvalid. Required: next cycle all valids/readies are 0, grant=00, and the counters are 0.
